// File: rtl/seq_divsub_16bit.sv
// Multi-cycle restoring divider: one quotient bit per cycle, with sign fix-up
// and the adder's 7FFF/8000 clamp on divide-by-zero and signed overflow.
module seq_divsub_16bit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             signed_op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Quot,
  output logic [WIDTH-1:0] Rem,
  output logic             Error
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] SAT_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;    // partial remainder (magnitude)
  logic [WIDTH-1:0] quo_q, quo_d;    // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sgn_q, sgn_d;
  logic             divz_q, divz_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             err_q, err_d;

  logic             sa, sb;
  logic [WIDTH-1:0] bmag;
  logic [WIDTH:0]   rem_sh;
  logic             ge;
  logic [WIDTH-1:0] diff;

  assign sa     = sgn_q & a_q[WIDTH-1];
  assign sb     = sgn_q & b_q[WIDTH-1];
  assign bmag   = sb ? -b_q : b_q;
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign ge     = (rem_sh >= {1'b0, bmag});
  // When ge holds the true difference is below bmag, so the low bits suffice.
  assign diff   = rem_sh[WIDTH-1:0] - bmag;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    divz_d  = divz_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d    = A;
          b_d    = B;
          sgn_d  = signed_op;
          quo_d  = (signed_op && A[WIDTH-1]) ? -A : A;
          rem_d  = '0;
          cnt_d  = '0;
          divz_d = (B == '0);
          state_d = (B == '0) ? FIX : CALC;
        end
      end
      CALC: begin
        rem_d = ge ? diff : rem_sh[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = FIX;
      end
      FIX: begin
        if (divz_q) begin
          quot_d = !sgn_q ? '1 : (sa ? SAT_MIN : SAT_MAX);
          remo_d = a_q;
          err_d  = 1'b1;
        end else if (sgn_q && a_q == SAT_MIN && b_q == '1) begin
          quot_d = SAT_MAX;
          remo_d = '0;
          err_d  = 1'b1;
        end else begin
          quot_d = (sa ^ sb) ? -quo_q : quo_q;
          remo_d = sa ? -rem_q : rem_q;
          err_d  = 1'b0;
        end
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      divz_q  <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      divz_q  <= divz_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      err_q   <= err_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  assign Quot  = quot_q;
  assign Rem   = remo_q;
  assign Error = err_q;

endmodule

// File: tb/tb_seq_divsub_16bit.sv
// Vector table plus handshake/reset sequences; expected results go through a queue.
module tb_seq_divsub_16bit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] A = '0, B = '0;
  logic        signed_op = 1'b0;
  logic        busy, done, Error;
  logic [15:0] Quot, Rem;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [15:0] a, b;
    logic        s;
    logic [15:0] q, r;
    logic        e;
    int          lat;
  } vec_t;

  typedef struct {
    logic [15:0] q, r;
    logic        e;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[14];

  seq_divsub_16bit #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .signed_op(signed_op),
    .busy(busy), .done(done), .Quot(Quot), .Rem(Rem), .Error(Error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Issue one operation; glitch>0 re-asserts start with junk operands in that cycle.
  task automatic do_op(input vec_t v, input int glitch);
    int   cyc;
    logic all_busy;
    exp_t e;
    @(posedge clk); #1;
    chk("idle_busy", busy, 1'b0);
    chk("idle_done", done, 1'b0);
    A = v.a; B = v.b; signed_op = v.s; start = 1'b1;
    e.q = v.q; e.r = v.r; e.e = v.e;
    sb_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    A = 16'($urandom); B = 16'($urandom); signed_op = 1'($urandom);
    cyc = 1;
    all_busy = busy;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (!done) all_busy &= busy;
      if (cyc == glitch) begin
        start = 1'b1; A = 16'h0010; B = 16'h0002; signed_op = 1'b1;
      end else start = 1'b0;
    end
    start = 1'b0;
    chk("busy_run", all_busy, 1'b1);
    chk("latency", cyc, v.lat);
    chk("busy_at_done", busy, 1'b1);
    if (sb_q.size() == 0) begin
      bad++; total++;
      $display("FAIL scoreboard: got done want nothing pending");
    end else begin
      e = sb_q.pop_front();
      chk("quot", Quot, e.q);
      chk("rem", Rem, e.r);
      chk("error", Error, e.e);
    end
  endtask

  initial begin
    int ndone;
    vec_t v;
    vecs[0]  = '{16'h0064, 16'h0007, 1'b0, 16'h000E, 16'h0002, 1'b0, 18};
    vecs[1]  = '{16'hFF9C, 16'h0007, 1'b1, 16'hFFF2, 16'hFFFE, 1'b0, 18};
    vecs[2]  = '{16'h0064, 16'hFFF9, 1'b1, 16'hFFF2, 16'h0002, 1'b0, 18};
    vecs[3]  = '{16'h1234, 16'h0000, 1'b0, 16'hFFFF, 16'h1234, 1'b1, 2};
    vecs[4]  = '{16'hF000, 16'h0000, 1'b1, 16'h8000, 16'hF000, 1'b1, 2};
    vecs[5]  = '{16'h8000, 16'hFFFF, 1'b1, 16'h7FFF, 16'h0000, 1'b1, 18};
    vecs[6]  = '{16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 18};
    vecs[7]  = '{16'h0064, 16'h0000, 1'b1, 16'h7FFF, 16'h0064, 1'b1, 2};
    vecs[8]  = '{16'h8000, 16'h0001, 1'b1, 16'h8000, 16'h0000, 1'b0, 18};
    vecs[9]  = '{16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 16'h0000, 1'b0, 18};
    vecs[10] = '{16'h7FFF, 16'h0002, 1'b1, 16'h3FFF, 16'h0001, 1'b0, 18};
    vecs[11] = '{16'h8000, 16'hFFFF, 1'b0, 16'h0000, 16'h8000, 1'b0, 18};
    vecs[12] = '{16'hFF9C, 16'hFFF9, 1'b1, 16'h000E, 16'hFFFE, 1'b0, 18};
    vecs[13] = '{16'h1234, 16'h0100, 1'b0, 16'h0012, 16'h0034, 1'b0, 18};

    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_quot", Quot, 16'h0);
    chk("rst_rem", Rem, 16'h0);
    chk("rst_err", Error, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    // Back-to-back: each op starts in the cycle after the previous done.
    foreach (vecs[i]) do_op(vecs[i], 0);

    // Start while busy in cycle 5 must be ignored.
    do_op(vecs[0], 5);
    do_op(vecs[1], 0);
    do_op(vecs[13], 0);

    // Reset in cycle 9 of an operation: outputs clear without a clock edge.
    @(posedge clk); #1;
    A = 16'h0064; B = 16'h0007; signed_op = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_quot", Quot, 16'h0);
    chk("arst_rem", Rem, 16'h0);
    chk("arst_err", Error, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("no_done_after_rst", ndone, 0);
    chk("idle_after_rst", busy, 1'b0);
    v = vecs[2];
    do_op(v, 0);
    v = vecs[4];
    do_op(v, 0);

    chk("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
